// File: rtl/apb_master_req.sv
// Single-outstanding APB requester: turns a valid/ready command into one
// APB SETUP/ACCESS transfer and returns one response (data, error, timeout).
module apb_master_req #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  // command port
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_SIZE-1:0]   cmd_addr,
  input  logic [DATA_SIZE-1:0]   cmd_wdata,
  input  logic [DATA_SIZE/8-1:0] cmd_strb,
  // response port
  output logic                   rsp_valid,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  // APB requester side
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTRB,
  input  logic                   PREADY,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PSLVERR
);

  localparam int unsigned STRB_W  = DATA_SIZE / 8;
  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Whole requester: state, APB drive and response capture all registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_wdata;
            PSTRB     <= cmd_write ? cmd_strb : STRB_W'(0);
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end else begin
            // first IDLE cycle after reset release re-opens the command port
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            // a ready slave wins even on the cycle the timeout would fire
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? DATA_SIZE'(0) : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TO_LAST))) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
